// File: rtl/prm_edge_scan_seq.sv
// prm_edge_scan_seq: sweeps checker query codes and packs edge_mask
// replies into words on a valid/ready stream.
module prm_edge_scan_seq #(
  parameter int WORD_W = 32,
  parameter int CODE_W = 15,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] code_base,
  input  logic [CNT_W-1:0]  code_count,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] chk_code,
  input  logic              chk_mask,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic [CNT_W-1:0]  blocked_cnt
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    DRAIN
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] pack;
  logic [WORD_W-1:0] pack_nx;

  logic accept;
  logic stall;
  logic final_code;
  logic complete;
  logic step;
  logic go;
  logic zero_go;
  logic finish;

  assign accept     = word_valid & word_ready;
  assign stall      = word_valid & ~word_ready;
  assign final_code = (remaining == CNT_W'(1));
  assign complete   = (idx == IDX_W'(WORD_W - 1)) | final_code;
  assign pack_nx    = pack | (WORD_W'(chk_mask) << idx);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and per-cycle action decode
  always_comb begin
    state_nx = state;
    step     = 1'b0;
    go       = 1'b0;
    zero_go  = 1'b0;
    finish   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (code_count == '0) begin
            zero_go = 1'b1;
          end else begin
            go       = 1'b1;
            state_nx = SCAN;
          end
        end
      end
      SCAN, FLUSH: begin
        if (stall) begin
          state_nx = FLUSH;
        end else begin
          step     = 1'b1;
          state_nx = final_code ? DRAIN : SCAN;
        end
      end
      DRAIN: begin
        if (accept | ~word_valid) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sweep datapath, pack register and one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      chk_code    <= '0;
      remaining   <= '0;
      idx         <= '0;
      pack        <= '0;
      word_data   <= '0;
      word_valid  <= 1'b0;
      word_last   <= 1'b0;
      blocked_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        word_valid <= 1'b0;
      end
      if (zero_go) begin
        done        <= 1'b1;
        blocked_cnt <= '0;
      end
      if (go) begin
        chk_code    <= code_base;
        remaining   <= code_count;
        blocked_cnt <= '0;
        busy        <= 1'b1;
        idx         <= '0;
        pack        <= '0;
      end
      if (step) begin
        chk_code    <= chk_code + 1'b1;
        remaining   <= remaining - 1'b1;
        blocked_cnt <= blocked_cnt + CNT_W'(chk_mask);
        if (complete) begin
          word_data  <= pack_nx;
          word_last  <= final_code;
          word_valid <= 1'b1;
          pack       <= '0;
          idx        <= '0;
        end else begin
          pack <= pack_nx;
          idx  <= idx + 1'b1;
        end
      end
      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_scan_seq.sv
// tb_prm_edge_scan_seq: directed and randomized sweeps against a
// bit-list reference model of the checker bitmap.
module tb_prm_edge_scan_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] code_base;
  logic [15:0] code_count;
  logic        busy;
  logic        done;
  logic [14:0] chk_code;
  logic        chk_mask;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        word_last;
  logic [15:0] blocked_cnt;

  int tests = 0;
  int fails = 0;
  int mmode = 0;

  logic [31:0] got_w[$];
  logic        got_l[$];
  logic [31:0] exp_w[$];
  int          exp_pop;
  logic        saw_wrap;

  always #5 clk = ~clk;

  prm_edge_scan_seq #(
    .WORD_W(32),
    .CODE_W(15),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .code_base  (code_base),
    .code_count (code_count),
    .busy       (busy),
    .done       (done),
    .chk_code   (chk_code),
    .chk_mask   (chk_mask),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_last  (word_last),
    .blocked_cnt(blocked_cnt)
  );

  function automatic logic ref_chk(input logic [14:0] c);
    return (^(c & 15'h5A3C)) ^ (c[14] & c[0]) ^ (c[7:4] == 4'hB);
  endfunction

  assign chk_mask = (mmode == 0) ? 1'b1 : ref_chk(chk_code);

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_model(input int base, input int cnt);
    logic [31:0] w;
    int bi;
    int c;
    exp_w.delete();
    exp_pop = 0;
    w = '0;
    bi = 0;
    for (int k = 0; k < cnt; k++) begin
      c = (base + k) % 32768;
      if ((mmode == 0) || ref_chk(c[14:0])) begin
        w[bi] = 1'b1;
        exp_pop++;
      end
      bi++;
      if (bi == 32 || k == cnt - 1) begin
        exp_w.push_back(w);
        w = '0;
        bi = 0;
      end
    end
  endtask

  task automatic run_sweep(input string name, input int base,
                           input int cnt, input int rmode,
                           output int first_v, output int done_c);
    int cyc;
    int hold;
    int stab_err;
    int freeze_err;
    int budget;
    logic [31:0] prev_d;
    logic prev_l;
    logic prev_stall;
    got_w.delete();
    got_l.delete();
    first_v = -1;
    done_c = -1;
    hold = 0;
    stab_err = 0;
    freeze_err = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    saw_wrap = 1'b0;
    budget = cnt * 2 + 200;
    build_model(base, cnt);
    @(negedge clk);
    code_base = base[14:0];
    code_count = cnt[15:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    code_base = ~code_base;
    code_count = 16'h0005;
    cyc = 1;
    if (cnt > 0) begin
      check({name, " first code"}, chk_code, base[14:0]);
      check({name, " busy"}, busy, 1'b1);
    end else begin
      check({name, " busy idle"}, busy, 1'b0);
    end
    while (cyc < budget) begin
      if (done) begin
        done_c = cyc;
        break;
      end
      if (word_valid && first_v < 0) first_v = cyc;
      if (prev_stall && (!word_valid || word_data !== prev_d ||
                         word_last !== prev_l))
        stab_err++;
      if (chk_code == 15'h0000) saw_wrap = 1'b1;
      if (rmode == 0) begin
        word_ready = 1'b1;
      end else if (rmode == 1) begin
        word_ready = ($urandom_range(3) != 0);
      end else if (first_v >= 0 && hold < 50) begin
        word_ready = 1'b0;
        if (chk_code !== 15'(base + 32)) freeze_err++;
        hold++;
      end else begin
        word_ready = 1'b1;
      end
      if (word_valid && word_ready) begin
        got_w.push_back(word_data);
        got_l.push_back(word_last);
      end
      prev_stall = word_valid && !word_ready;
      prev_d = word_data;
      prev_l = word_last;
      @(negedge clk);
      cyc++;
    end
    check({name, " done seen"}, (done_c >= 0), 1'b1);
    check({name, " busy at done"}, busy, 1'b0);
    check({name, " word count"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++) begin
      check({name, " word"}, got_w[i], exp_w[i]);
      check({name, " last"}, got_l[i], (i == exp_w.size() - 1));
    end
    check({name, " blocked_cnt"}, blocked_cnt, exp_pop);
    check({name, " stall stable"}, stab_err, 0);
    if (rmode == 2) begin
      check({name, " hold cycles"}, hold, 50);
      check({name, " code freeze"}, freeze_err, 0);
    end
  endtask

  initial begin
    int fv;
    int dc;
    int err;
    rst = 1'b1;
    start = 1'b0;
    code_base = '0;
    code_count = '0;
    word_ready = 1'b0;
    mmode = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst valid", word_valid, 1'b0);
    check("rst last", word_last, 1'b0);
    check("rst data", word_data, 32'h0);
    check("rst code", chk_code, 15'h0);
    check("rst blocked", blocked_cnt, 16'h0);

    mmode = 0;
    run_sweep("t1", 0, 32, 0, fv, dc);
    check("t1 first valid cyc", fv, 33);
    check("t1 done cyc", dc, 34);
    check("t1 word", got_w[0], 32'hFFFF_FFFF);
    check("t1 blocked", blocked_cnt, 16'd32);

    mmode = 1;
    run_sweep("t2", 32'h7FF0, 40, 0, fv, dc);
    check("t2 wrap", saw_wrap, 1'b1);
    check("t2 upper zero", got_w[1] >> 8, 32'h0);

    run_sweep("t3", 32'h1234, 64, 2, fv, dc);
    check("t3 first valid cyc", fv, 33);

    run_sweep("t4", 32'h0055, 0, 0, fv, dc);
    check("t4 done cyc", dc, 1);
    check("t4 blocked clr", blocked_cnt, 16'h0);

    @(negedge clk);
    word_ready = 1'b1;
    code_base = 15'h0100;
    code_count = 16'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    code_base = 15'h4000;
    code_count = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5 restart ignored", chk_code, 15'h0106);
    check("t5 busy", busy, 1'b1);
    repeat (20) @(negedge clk);
    check("t5 mid code", chk_code, 15'h011A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 rst busy", busy, 1'b0);
    check("t5 rst valid", word_valid, 1'b0);
    check("t5 rst code", chk_code, 15'h0);
    check("t5 rst blocked", blocked_cnt, 16'h0);
    check("t5 rst data", word_data, 32'h0);
    err = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || word_valid || busy) err++;
      @(negedge clk);
    end
    check("t5 quiet after rst", err, 0);

    run_sweep("t6", 0, 32768, 1, fv, dc);
    check("t6 words", got_w.size(), 1024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
